// File: rtl/core_pkg.sv
// Shared definitions for the back-end pipeline stages: access sizes,
// MEM-stage FSM states and the hard-wired zero register.
package core_pkg;

  localparam logic [1:0] MSZ_B = 2'b00;
  localparam logic [1:0] MSZ_H = 2'b01;
  localparam logic [1:0] MSZ_W = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the data-memory port: store byte enables and
// lane replication, load extraction/extension, and the alignment check.
module mem_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  input  logic            load_unsigned,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted    = rdata >> {addr_lo, 3'b000};
    be         = 4'b0000;
    wdata      = store_data;
    load_data  = shifted;
    misaligned = 1'b0;
    case (size)
      MSZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = load_unsigned ? {24'd0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      end
      MSZ_H: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_data  = load_unsigned ? {16'd0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      // Word access; the unused encoding is treated the same way.
      default: begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = shifted;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM and WB pipeline stages: data-memory access with wait-state handshake,
// forwarding sources for EX, and the register-file write port.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [4:0]        ex_dest,
  input  logic              ex_write_enable,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_load_unsigned,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [4:0]        mem_dest,
  output logic              mem_write_enable,
  output logic [XLEN-1:0]   mem_data,
  output logic [4:0]        wb_dest,
  output logic              wb_write_enable,
  output logic [XLEN-1:0]   wb_data,
  output logic              mem_stall,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] misalign_addr
);

  logic            mem_valid;
  logic            mem_is_load;
  logic            mem_is_store;
  logic            mem_wen;
  logic            mem_unsigned;
  logic [1:0]      mem_size;
  logic [XLEN-1:0] mem_alu;
  logic [XLEN-1:0] mem_store_data;

  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] load_data;
  logic            misaligned;
  logic            mem_access;
  logic            mis_access;
  logic            reg_write;

  mem_state_t state, state_next;

  mem_align #(.XLEN(XLEN)) u_align (
    .addr_lo       (mem_alu[1:0]),
    .size          (mem_size),
    .store_data    (mem_store_data),
    .rdata         (dmem_rdata),
    .load_unsigned (mem_unsigned),
    .be            (lane_be),
    .wdata         (lane_wdata),
    .load_data     (load_data),
    .misaligned    (misaligned)
  );

  // MEM register holds its contents while the access waits on the memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid      <= 1'b0;
      mem_is_load    <= 1'b0;
      mem_is_store   <= 1'b0;
      mem_wen        <= 1'b0;
      mem_unsigned   <= 1'b0;
      mem_size       <= MSZ_B;
      mem_alu        <= '0;
      mem_store_data <= '0;
      mem_dest       <= REG_ZERO;
    end else if (!mem_stall) begin
      if (ex_valid) begin
        mem_valid      <= 1'b1;
        mem_is_load    <= ex_mem_read;
        mem_is_store   <= ex_mem_write;
        mem_wen        <= ex_write_enable;
        mem_unsigned   <= ex_load_unsigned;
        mem_size       <= ex_mem_size;
        mem_alu        <= alu_result;
        mem_store_data <= ex_store_data;
        mem_dest       <= ex_dest;
      end else begin
        mem_valid      <= 1'b0;
        mem_is_load    <= 1'b0;
        mem_is_store   <= 1'b0;
        mem_wen        <= 1'b0;
        mem_unsigned   <= 1'b0;
        mem_size       <= MSZ_B;
        mem_alu        <= '0;
        mem_store_data <= '0;
        mem_dest       <= REG_ZERO;
      end
    end
  end

  // Alignment only matters for real memory ops; ALU results may be odd.
  assign mem_access = mem_valid & (mem_is_load | mem_is_store);
  assign mis_access = mem_access & misaligned;

  assign dmem_req   = mem_access & ~misaligned;
  assign dmem_we    = dmem_req & mem_is_store;
  assign dmem_addr  = dmem_req ? {mem_alu[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be    = dmem_req ? lane_be : 4'b0000;
  assign dmem_wdata = dmem_req ? lane_wdata : '0;
  assign mem_stall  = dmem_req & ~dmem_ready;

  assign mem_write_enable = mem_valid & mem_wen & ~mem_is_load & (mem_dest != REG_ZERO);
  assign mem_data         = mem_alu;

  assign reg_write = mem_valid & mem_wen & ~mem_is_store & ~mis_access
                   & (mem_dest != REG_ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (dmem_req && !dmem_ready) state_next = WAIT;
      WAIT:    if (dmem_ready) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // WB register takes a bubble for every cycle the access is still waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_dest         <= REG_ZERO;
      wb_write_enable <= 1'b0;
      wb_data         <= '0;
    end else if (mem_stall) begin
      wb_dest         <= REG_ZERO;
      wb_write_enable <= 1'b0;
      wb_data         <= '0;
    end else begin
      wb_dest         <= mem_dest;
      wb_write_enable <= reg_write;
      wb_data         <= mem_is_load ? load_data : mem_alu;
    end
  end

  // Only the first misaligned access is recorded until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else if (mis_access && !misalign_err) begin
      misalign_err  <= 1'b1;
      misalign_addr <= mem_alu[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: ALU pass-through, loads with
// wait states, stores, misalignment, x0 writes and reset during a wait.
module tb_mem_wb_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid;
  logic [31:0] alu_result;
  logic [4:0]  ex_dest;
  logic        ex_write_enable;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [31:0] ex_store_data;
  logic [1:0]  ex_mem_size;
  logic        ex_load_unsigned;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [4:0]  mem_dest;
  logic        mem_write_enable;
  logic [31:0] mem_data;
  logic [4:0]  wb_dest;
  logic        wb_write_enable;
  logic [31:0] wb_data;
  logic        mem_stall;
  logic        misalign_err;
  logic [15:0] misalign_addr;

  int checks;
  int errors;

  mem_wb_stage #(.XLEN(32), .ADDR_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .alu_result       (alu_result),
    .ex_dest          (ex_dest),
    .ex_write_enable  (ex_write_enable),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_store_data    (ex_store_data),
    .ex_mem_size      (ex_mem_size),
    .ex_load_unsigned (ex_load_unsigned),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_be          (dmem_be),
    .dmem_wdata       (dmem_wdata),
    .dmem_ready       (dmem_ready),
    .dmem_rdata       (dmem_rdata),
    .mem_dest         (mem_dest),
    .mem_write_enable (mem_write_enable),
    .mem_data         (mem_data),
    .wb_dest          (wb_dest),
    .wb_write_enable  (wb_write_enable),
    .wb_data          (wb_data),
    .mem_stall        (mem_stall),
    .misalign_err     (misalign_err),
    .misalign_addr    (misalign_addr)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic v, input logic [31:0] alu, input logic [4:0] dest,
                                input logic wen, input logic rd, input logic wr,
                                input logic [31:0] sdata, input logic [1:0] size,
                                input logic uns);
    ex_valid         = v;
    alu_result       = alu;
    ex_dest          = dest;
    ex_write_enable  = wen;
    ex_mem_read      = rd;
    ex_mem_write     = wr;
    ex_store_data    = sdata;
    ex_mem_size      = size;
    ex_load_unsigned = uns;
    #1;
  endtask

  task automatic apply_idle();
    apply_stimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, MSZ_B, 1'b0);
  endtask

  task automatic set_memory(input logic ready, input logic [31:0] rdata);
    dmem_ready = ready;
    dmem_rdata = rdata;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    apply_idle();
    set_memory(1'b0, 32'd0);

    rst = 1'b0;
    #2;
    check_output("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check_output("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    check_output("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    check_output("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
    check_output("rst_wb_we", {31'd0, wb_write_enable}, 32'd0);
    check_output("rst_misalign_err", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] ADD x5 = 0x1234");
    apply_stimulus(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, MSZ_W, 1'b0);
    step();
    apply_idle();
    check_output("add_mem_data", mem_data, 32'h0000_1234);
    check_output("add_mem_we", {31'd0, mem_write_enable}, 32'd1);
    check_output("add_mem_dest", {27'd0, mem_dest}, 32'd5);
    check_output("add_stall_n", {31'd0, mem_stall}, 32'd0);
    check_output("add_no_req", {31'd0, dmem_req}, 32'd0);
    step();
    check_output("add_wb_data", wb_data, 32'h0000_1234);
    check_output("add_wb_we", {31'd0, wb_write_enable}, 32'd1);
    check_output("add_wb_dest", {27'd0, wb_dest}, 32'd5);
    check_output("add_stall_n1", {31'd0, mem_stall}, 32'd0);

    $display("[TB] LB x6 @0x0103 with two wait cycles");
    apply_stimulus(1'b1, 32'h0000_0103, 5'd6, 1'b1, 1'b1, 1'b0, 32'd0, MSZ_B, 1'b0);
    step();
    apply_idle();
    check_output("lb_req", {31'd0, dmem_req}, 32'd1);
    check_output("lb_we", {31'd0, dmem_we}, 32'd0);
    check_output("lb_addr", {16'd0, dmem_addr}, 32'h0000_0100);
    check_output("lb_stall_w1", {31'd0, mem_stall}, 32'd1);
    check_output("lb_no_mem_fwd", {31'd0, mem_write_enable}, 32'd0);
    step();
    check_output("lb_stall_w2", {31'd0, mem_stall}, 32'd1);
    check_output("lb_addr_hold", {16'd0, dmem_addr}, 32'h0000_0100);
    check_output("lb_wb_bubble", {31'd0, wb_write_enable}, 32'd0);
    step();
    set_memory(1'b1, 32'h80AA_BBCC);
    check_output("lb_stall_done", {31'd0, mem_stall}, 32'd0);
    step();
    set_memory(1'b0, 32'd0);
    check_output("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check_output("lb_wb_we", {31'd0, wb_write_enable}, 32'd1);
    check_output("lb_wb_dest", {27'd0, wb_dest}, 32'd6);

    $display("[TB] LBU x6 @0x0103 zero wait");
    apply_stimulus(1'b1, 32'h0000_0103, 5'd6, 1'b1, 1'b1, 1'b0, 32'd0, MSZ_B, 1'b1);
    step();
    apply_idle();
    set_memory(1'b1, 32'h80AA_BBCC);
    check_output("lbu_req", {31'd0, dmem_req}, 32'd1);
    check_output("lbu_stall", {31'd0, mem_stall}, 32'd0);
    step();
    set_memory(1'b0, 32'd0);
    check_output("lbu_wb_data", wb_data, 32'h0000_0080);

    $display("[TB] SH @0x0202 data 0x1111ABCD");
    apply_stimulus(1'b1, 32'h0000_0202, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1111_ABCD, MSZ_H, 1'b0);
    step();
    apply_idle();
    set_memory(1'b1, 32'd0);
    check_output("sh_be", {28'd0, dmem_be}, 32'h0000_000C);
    check_output("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    check_output("sh_we", {31'd0, dmem_we}, 32'd1);
    check_output("sh_addr", {16'd0, dmem_addr}, 32'h0000_0200);
    check_output("sh_stall", {31'd0, mem_stall}, 32'd0);
    step();
    set_memory(1'b0, 32'd0);
    check_output("sh_wb_we", {31'd0, wb_write_enable}, 32'd0);

    $display("[TB] misaligned LW @0x0006 then @0x0009");
    apply_stimulus(1'b1, 32'h0000_0006, 5'd7, 1'b1, 1'b1, 1'b0, 32'd0, MSZ_W, 1'b0);
    step();
    apply_idle();
    set_memory(1'b1, 32'h1234_5678);
    check_output("mis_no_req", {31'd0, dmem_req}, 32'd0);
    check_output("mis_no_stall", {31'd0, mem_stall}, 32'd0);
    step();
    set_memory(1'b0, 32'd0);
    check_output("mis_err", {31'd0, misalign_err}, 32'd1);
    check_output("mis_addr", {16'd0, misalign_addr}, 32'h0000_0006);
    check_output("mis_wb_we", {31'd0, wb_write_enable}, 32'd0);
    apply_stimulus(1'b1, 32'h0000_0009, 5'd7, 1'b1, 1'b1, 1'b0, 32'd0, MSZ_W, 1'b0);
    step();
    apply_idle();
    check_output("mis2_no_req", {31'd0, dmem_req}, 32'd0);
    step();
    check_output("mis2_err", {31'd0, misalign_err}, 32'd1);
    check_output("mis2_addr_kept", {16'd0, misalign_addr}, 32'h0000_0006);
    check_output("mis2_wb_we", {31'd0, wb_write_enable}, 32'd0);

    $display("[TB] write to x0");
    apply_stimulus(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0, MSZ_W, 1'b0);
    step();
    apply_idle();
    check_output("x0_mem_data", mem_data, 32'hDEAD_BEEF);
    check_output("x0_mem_we", {31'd0, mem_write_enable}, 32'd0);
    step();
    check_output("x0_wb_we", {31'd0, wb_write_enable}, 32'd0);

    $display("[TB] reset while waiting on memory");
    apply_stimulus(1'b1, 32'h0000_0010, 5'd8, 1'b1, 1'b1, 1'b0, 32'd0, MSZ_W, 1'b0);
    step();
    apply_idle();
    check_output("rw_stall1", {31'd0, mem_stall}, 32'd1);
    step();
    check_output("rw_stall2", {31'd0, mem_stall}, 32'd1);
    rst = 1'b0;
    #1;
    check_output("rw_req_drop", {31'd0, dmem_req}, 32'd0);
    check_output("rw_stall_drop", {31'd0, mem_stall}, 32'd0);
    check_output("rw_err_clear", {31'd0, misalign_err}, 32'd0);
    check_output("rw_addr_clear", {16'd0, misalign_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b1, 32'h0000_0055, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, MSZ_W, 1'b0);
    step();
    apply_idle();
    check_output("post_mem_data", mem_data, 32'h0000_0055);
    check_output("post_mem_we", {31'd0, mem_write_enable}, 32'd1);
    check_output("post_stall", {31'd0, mem_stall}, 32'd0);
    step();
    check_output("post_wb_data", wb_data, 32'h0000_0055);
    check_output("post_wb_we", {31'd0, wb_write_enable}, 32'd1);
    check_output("post_wb_dest", {27'd0, wb_dest}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
